// File: rtl/corescore_act_stretch.sv
// ---------------------------------------------------------------------------
// corescore_act_stretch
//   One activity LED channel: an optional input synchroniser, polarity
//   normalisation and a retriggerable pulse stretcher. The LED stays lit for
//   STRETCH_CYCLES cycles after the last active sample, so short bursts such
//   as UART characters remain visible.
//
// Parameters
//   STRETCH_CYCLES  cycles o_act stays high after the last active sample (>= 1)
//   ACTIVE_LOW      1: i_act is active when low (e.g. an idle-high UART tx line)
//   SYNC_STAGES     synchroniser flops on i_act; 0 uses the raw input directly
//
// Ports
//   clk    in   fabric clock
//   rst    in   synchronous, active-high reset
//   i_act  in   raw activity input
//   o_act  out  stretched activity, active-high, registered
// ---------------------------------------------------------------------------
module corescore_act_stretch #(
    parameter int STRETCH_CYCLES = 1600000,
    parameter bit ACTIVE_LOW     = 1'b0,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_act,
    output logic o_act
);

    localparam int             CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(STRETCH_CYCLES);

    logic             sampled;
    logic             act_n;
    logic [CNT_W-1:0] cnt;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sampled = i_act;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: the chain resets to the channel's idle level, otherwise an
            // active-low channel would flash its LED on every reset release.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
                end else begin
                    sync_q[0] <= i_act;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign sampled = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign act_n = sampled ^ ACTIVE_LOW;

    // The counter holds the remaining lit cycles including the current one,
    // so the LED stays on while more than one remains; a retrigger simply
    // reloads it and o_act never drops in between.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            o_act <= 1'b0;
        end else begin
            if (act_n) begin
                cnt <= LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            o_act <= act_n || (cnt > CNT_W'(1));
        end
    end

endmodule

// File: rtl/corescore_status_leds.sv
// ---------------------------------------------------------------------------
// corescore_status_leds
//   Board status LEDs for corescore tops: a heartbeat that blinks fast while
//   a fault is latched, a sticky fault flag, and N_ACT stretched activity LEDs.
//
// Parameters
//   HB_HALF_CYCLES  cycles between heartbeat toggles in normal mode (>= 2)
//   FAULT_DIV       fault-mode toggle interval is HB_HALF_CYCLES/FAULT_DIV
//   N_ACT           number of activity channels (>= 1)
//   STRETCH_CYCLES  cycles an activity LED stays lit after the last sample
//   ACT_ACTIVE_LOW  per-channel: 1 means that i_act bit is active when low
//   SYNC_STAGES     synchroniser flops on i_act and i_fault (0 = none)
//
// Ports
//   clk          in   fabric clock
//   rst          in   synchronous, active-high reset
//   i_act        in   raw activity inputs [N_ACT]
//   i_fault      in   fault request, level
//   i_fault_clr  in   clears the sticky fault flag (clk domain, unsynchronised)
//   o_hb         out  heartbeat LED
//   o_act        out  stretched activity LEDs [N_ACT], active-high
//   o_fault      out  sticky fault flag
// ---------------------------------------------------------------------------
module corescore_status_leds #(
    parameter int               HB_HALF_CYCLES = 16000000,
    parameter int               FAULT_DIV      = 8,
    parameter int               N_ACT          = 2,
    parameter int               STRETCH_CYCLES = 1600000,
    parameter logic [N_ACT-1:0] ACT_ACTIVE_LOW = {N_ACT{1'b0}},
    parameter int               SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_ACT-1:0] i_act,
    input  logic             i_fault,
    input  logic             i_fault_clr,
    output logic             o_hb,
    output logic [N_ACT-1:0] o_act,
    output logic             o_fault
);

    localparam int              HB_W        = $clog2(HB_HALF_CYCLES);
    localparam logic [HB_W-1:0] NORM_LIMIT  = HB_W'(HB_HALF_CYCLES - 1);
    localparam logic [HB_W-1:0] FAULT_LIMIT = HB_W'(HB_HALF_CYCLES / FAULT_DIV - 1);

    // ---------------- activity channels ----------------
    generate
        for (genvar i = 0; i < N_ACT; i++) begin : g_act
            corescore_act_stretch #(
                .STRETCH_CYCLES(STRETCH_CYCLES),
                .ACTIVE_LOW    (ACT_ACTIVE_LOW[i]),
                .SYNC_STAGES   (SYNC_STAGES)
            ) u_stretch (
                .clk  (clk),
                .rst  (rst),
                .i_act(i_act[i]),
                .o_act(o_act[i])
            );
        end
    endgenerate

    // ---------------- fault input synchroniser ----------------
    logic fault_sampled;

    generate
        if (SYNC_STAGES == 0) begin : g_fault_no_sync
            assign fault_sampled = i_fault;
        end else begin : g_fault_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= i_fault;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign fault_sampled = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------- fault flag and heartbeat ----------------
    logic            fault_next;
    logic [HB_W-1:0] hb_limit;
    logic [HB_W-1:0] hb_cnt;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fault_next = o_fault;
        if (fault_sampled) begin
            fault_next = 1'b1;          // set wins over a simultaneous clear
        end else if (i_fault_clr) begin
            fault_next = 1'b0;
        end
        hb_limit = o_fault ? FAULT_LIMIT : NORM_LIMIT;
    end

    // A mode change restarts the count from 0, so the counter can never sit
    // above the shorter fault limit and the new blink rate shows at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_fault <= 1'b0;
            o_hb    <= 1'b0;
            hb_cnt  <= '0;
        end else begin
            o_fault <= fault_next;
            if (fault_next != o_fault) begin
                hb_cnt <= '0;
            end else if (hb_cnt == hb_limit) begin
                hb_cnt <= '0;
                o_hb   <= ~o_hb;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_corescore_status_leds.sv
// ---------------------------------------------------------------------------
// tb_corescore_status_leds
//   Self-checking bench. A cycle-indexed reference model keeps the history of
//   every driven input and derives the outputs from timing rules:
//     - activity LED i is lit after edge m iff channel i was active in some
//       input slot k with m-SY-S <= k <= m-SY-1 (and k not before the last
//       reset edge);
//     - the fault flag follows set/clear of the input SY slots back, set wins;
//     - the heartbeat toggles when the time since the last toggle or mode
//       change equals the current mode's interval.
//   Input slot k is the value driven between edge k and edge k+1.
// ---------------------------------------------------------------------------
module tb_corescore_status_leds;

    localparam int         HB    = 10;
    localparam int         FD    = 5;
    localparam int         NA    = 2;
    localparam int         S     = 4;
    localparam int         SY    = 2;
    localparam logic [1:0] AL    = 2'b10;
    localparam logic [1:0] IDLE  = AL;      // inactive level of each channel
    localparam int         DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] i_act = IDLE;
    logic          i_fault = 1'b0;
    logic          i_fault_clr = 1'b0;
    logic          o_hb;
    logic [NA-1:0] o_act;
    logic          o_fault;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [NA-1:0] act_hist [DEPTH];
    logic          flt_hist [DEPTH];
    logic          clr_hist [DEPTH];
    int            g       = 0;     // index of the most recent edge
    int            r       = 0;     // index of the most recent reset edge
    int            last_ev = 0;     // edge of the last toggle or mode change
    logic          m_hb    = 1'b0;
    logic          m_fault = 1'b0;
    logic [NA-1:0] m_act   = '0;

    corescore_status_leds #(
        .HB_HALF_CYCLES(HB),
        .FAULT_DIV     (FD),
        .N_ACT         (NA),
        .STRETCH_CYCLES(S),
        .ACT_ACTIVE_LOW(AL),
        .SYNC_STAGES   (SY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_act      (i_act),
        .i_fault    (i_fault),
        .i_fault_clr(i_fault_clr),
        .o_hb       (o_hb),
        .o_act      (o_act),
        .o_fault    (o_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got g=%0d want finish", g);
        $fatal(1);
    end

    // Advance one clock edge, update the model, then step #1 past the edge.
    task automatic tick();
        logic rst_now;
        logic sf, clr, nf, on;
        if (g >= DEPTH - 2) begin
            $display("FAIL history_overflow got g=%0d want < %0d", g, DEPTH - 2);
            $fatal(1);
        end
        act_hist[g] = i_act;
        flt_hist[g] = i_fault;
        clr_hist[g] = i_fault_clr;
        rst_now     = rst;
        @(posedge clk);
        g = g + 1;
        if (rst_now) begin
            r       = g;
            last_ev = g;
            m_hb    = 1'b0;
            m_fault = 1'b0;
            m_act   = '0;
        end else begin
            sf  = (g - 1 - SY >= r) ? flt_hist[g-1-SY] : 1'b0;
            clr = clr_hist[g-1];
            nf  = sf ? 1'b1 : (clr ? 1'b0 : m_fault);
            if (nf !== m_fault) begin
                last_ev = g;
            end else if (g - last_ev == (m_fault ? HB / FD : HB)) begin
                m_hb    = ~m_hb;
                last_ev = g;
            end
            m_fault = nf;
            for (int i = 0; i < NA; i++) begin
                on = 1'b0;
                for (int k = g - SY - S; k <= g - 1 - SY; k++) begin
                    if (k >= r && k >= 0 && (act_hist[k][i] ^ AL[i])) on = 1'b1;
                end
                m_act[i] = on;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_act = IDLE; i_fault = 1'b0; i_fault_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_hb, o_act, o_fault} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got hb=%b act=%b fault=%b want all 0", o_hb, o_act, o_fault);
        end
        rst = 1'b0;
    endtask

    task automatic test_heartbeat();
        logic exp_hb;
        for (int n = 1; n <= 60; n++) begin
            tick();
            exp_hb = ((n / HB) % 2) == 1;
            checks++;
            if (o_hb !== exp_hb || o_act !== 2'b00 || o_fault !== 1'b0) begin
                failures++;
                $display("FAIL heartbeat_free n=%0d got hb=%b act=%b fault=%b want hb=%b act=00 fault=0",
                         n, o_hb, o_act, o_fault, exp_hb);
            end
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_heartbeat g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
    endtask

    // Pulses on channel 0 (active-high) in the slots listed by pulse_a/pulse_b.
    task automatic run_pulses(input string name, input int pulse_a, input int pulse_b,
                              input int want_rise, input int want_high);
        int high = 0, rises = 0, first = -1;
        logic prev = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            i_act = (n == pulse_a || n == pulse_b) ? (IDLE | 2'b01) : IDLE;
            tick();
            if (o_act[0]) high++;
            if (o_act[0] && !prev) begin
                rises++;
                if (first < 0) first = n;
            end
            prev = o_act[0];
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_%s g=%0d got %b%b%b want %b%b%b",
                         name, g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        i_act = IDLE;
        checks++;
        if (first != want_rise || high != want_high || rises != 1) begin
            failures++;
            $display("FAIL %s got rise=%0d high=%0d runs=%0d want rise=%0d high=%0d runs=1",
                     name, first, high, rises, want_rise, want_high);
        end
    endtask

    task automatic test_act_pulse();
        run_pulses("act_single", 1, -1, SY + 1, S);
        // Second pulse two slots later: lit from the first sample until S
        // cycles after the last one, 2 + S cycles in one run.
        run_pulses("act_retrigger", 1, 3, SY + 1, 2 + S);
    endtask

    task automatic test_act_low();
        int high = 0, first = -1, ch0_high = 0;
        for (int n = 1; n <= 14; n++) begin
            i_act = (n <= 3) ? 2'b00 : IDLE;
            tick();
            if (o_act[1]) begin
                high++;
                if (first < 0) first = n;
            end
            if (o_act[0]) ch0_high++;
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_act_low g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        i_act = IDLE;
        // Three active slots: lit from the first sample until S after the last.
        checks++;
        if (first != SY + 1 || high != 3 - 1 + S || ch0_high != 0) begin
            failures++;
            $display("FAIL act_low got rise=%0d high=%0d ch0_high=%0d want rise=%0d high=%0d ch0_high=0",
                     first, high, ch0_high, SY + 1, 3 - 1 + S);
        end
    endtask

    task automatic test_fault();
        int toggles = 0, early = 0;
        logic prev;
        logic set_ok = 1'b1;
        logic clr_ok = 1'b1;
        prev = o_hb;
        for (int n = 1; n <= 14; n++) begin
            i_fault = (n == 1);
            tick();
            if (o_fault !== (n >= SY + 1)) set_ok = 1'b0;
            if (n >= 4 && n <= 13 && o_hb != prev) toggles++;
            prev = o_hb;
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_fault_set g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        i_fault = 1'b0;
        checks++;
        if (!set_ok || toggles != 5) begin
            failures++;
            $display("FAIL fault_set got timing_ok=%b fast_toggles=%0d want timing_ok=1 fast_toggles=5",
                     set_ok, toggles);
        end
        toggles = 0;
        for (int n = 1; n <= 12; n++) begin
            i_fault_clr = (n == 1);
            tick();
            if (o_fault !== 1'b0) clr_ok = 1'b0;
            if (o_hb != prev) begin
                if (n == HB + 1) toggles++;
                else early++;
            end
            prev = o_hb;
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_fault_clr g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        i_fault_clr = 1'b0;
        checks++;
        if (!clr_ok || toggles != 1 || early != 0) begin
            failures++;
            $display("FAIL fault_clr got cleared=%b toggle_at_11=%0d other_toggles=%0d want 1 1 0",
                     clr_ok, toggles, early);
        end
    endtask

    task automatic test_set_wins();
        logic held = 1'b1;
        i_fault = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            i_fault_clr = (n == 5 || n == 6);
            tick();
            if (n >= SY + 1 && o_fault !== 1'b1) held = 1'b0;
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_set_wins g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        i_fault_clr = 1'b0;
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL set_wins got o_fault dropped want o_fault held at 1");
        end
    endtask

    // Fault still held from test_set_wins, so the fast blink is running.
    task automatic test_reset_mid();
        logic exp_hb;
        for (int n = 1; n <= 4; n++) begin
            i_act = (n <= 2) ? (IDLE | 2'b01) : IDLE;
            tick();
        end
        checks++;
        if (o_act[0] !== 1'b1 || o_fault !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup got act=%b fault=%b want act[0]=1 fault=1", o_act, o_fault);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_hb, o_act, o_fault} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got hb=%b act=%b fault=%b want all 0", o_hb, o_act, o_fault);
        end
        rst = 1'b0; i_fault = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_hb = (n >= HB);
            checks++;
            if (o_hb !== exp_hb || o_act !== 2'b00 || o_fault !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after n=%0d got hb=%b act=%b fault=%b want hb=%b act=00 fault=0",
                         n, o_hb, o_act, o_fault, exp_hb);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NA; i++) begin
                i_act[i] = ($urandom_range(0, 3) == 0) ^ AL[i];
            end
            i_fault     = ($urandom_range(0, 15) == 0);
            i_fault_clr = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if ({o_hb, o_act, o_fault} !== {m_hb, m_act, m_fault}) begin
                failures++;
                $display("FAIL model_random g=%0d got %b%b%b want %b%b%b",
                         g, o_hb, o_act, o_fault, m_hb, m_act, m_fault);
            end
        end
        rst = 1'b0; i_act = IDLE; i_fault = 1'b0; i_fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_act_pulse();
        test_act_low();
        test_fault();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
